rr_encoder_arbiter: RTL and testbench

- Round-robin arbiter sharing one downstream resource among 8 requesters.
- Produces a registered one-hot grant plus its 3-bit encoded index, matching the 8-to-3 encoder's input and output formats.
- Supports a hold/release handshake and a hold-timeout watchdog.
- Sits between requester blocks and the shared encoder/datapath; grant_idx drives the resource select.

---
 rtl/rr_encoder_arbiter.sv | 125 ++++++++++++
 tb/tb_rr_encoder_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rr_encoder_arbiter.sv
// rr_encoder_arbiter
//   Round-robin arbiter that shares one downstream resource among N requesters.
//   It drives a registered one-hot grant together with the grant's binary index,
//   which feeds the resource select. An owner keeps the grant until it asserts
//   done, drops its request, or reaches the hold limit. After every release the
//   arbiter spends exactly one cycle idle before it grants again.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req[N]       request vector; bit i set means requester i wants the resource
//   done         the current owner has finished and releases the grant
//   grant[N]     registered one-hot grant; all zero while idle
//   grant_idx    binary index of the granted requester; holds its value while idle
//   grant_valid  high while grant is non-zero
//   timeout      one-cycle pulse in the idle cycle after a hold-limit release
module rr_encoder_arbiter #(
    parameter int N        = 8,
    parameter int IDXW     = 3,
    parameter int MAX_HOLD = 16,
    parameter int CNTW     = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_valid,
    output logic            timeout
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    // Last hold count before a forced release. With MAX_HOLD == 0 this is all
    // ones and only acts as the saturation point, because the limit is disabled.
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(MAX_HOLD - 1);

    state_t            state_q;
    logic [IDXW-1:0]   ptr_q;
    logic [CNTW-1:0]   hold_cnt_q;
    logic [N-1:0]      grant_q;
    logic [IDXW-1:0]   grant_idx_q;
    logic              grant_valid_q;
    logic              timeout_q;

    logic              win_found_d;
    logic [IDXW-1:0]   win_idx_d;
    logic [IDXW-1:0]   cand;
    logic              rel_normal;
    logic              rel_limit;

    // Scan in circular order from ptr. The index arithmetic wraps naturally
    // because N == 2**IDXW.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = '0;
        cand        = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = ptr_q + IDXW'(off);
            if (!win_found_d && req[cand]) begin
                win_found_d = 1'b1;
                win_idx_d   = cand;
            end
        end
    end

    // A hold-limit release raises timeout only when no normal release
    // condition coincides with it.
    always_comb begin
        rel_normal = done || !req[grant_idx_q];
        rel_limit  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    timeout_q <= 1'b0;
                    if (win_found_d) begin
                        grant_q       <= {{(N-1){1'b0}}, 1'b1} << win_idx_d;
                        grant_idx_q   <= win_idx_d;
                        grant_valid_q <= 1'b1;
                        hold_cnt_q    <= '0;
                        state_q       <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (rel_normal || rel_limit) begin
                        grant_q       <= '0;
                        grant_valid_q <= 1'b0;
                        ptr_q         <= grant_idx_q + 1'b1;
                        timeout_q     <= !rel_normal && rel_limit;
                        state_q       <= S_IDLE;
                    end else begin
                        timeout_q <= 1'b0;
                        if (hold_cnt_q != HOLD_LAST) begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
module tb_rr_encoder_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;

    logic [7:0] a_grant, b_grant;
    logic [2:0] a_idx, b_idx;
    logic       a_valid, b_valid, a_to, b_to;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    // Instance a: hold limit disabled. Instance b: hold limit of 16 cycles.
    rr_encoder_arbiter #(.N(8), .IDXW(3), .MAX_HOLD(0), .CNTW(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(a_grant), .grant_idx(a_idx), .grant_valid(a_valid), .timeout(a_to)
    );

    rr_encoder_arbiter #(.N(8), .IDXW(3), .MAX_HOLD(16), .CNTW(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(b_grant), .grant_idx(b_idx), .grant_valid(b_valid), .timeout(b_to)
    );

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [7:0] grant;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] r, input logic d, input logic [7:0] g,
                        input logic [2:0] i, input logic v, input logic t);
        vec_t x;
        x.req = r; x.done = d; x.grant = g; x.idx = i; x.valid = v; x.to = t;
        vecs.push_back(x);
    endtask

    // Structural invariants on both instances, sampled away from the active edge.
    always @(negedge clk) begin
        logic ok;
        ok = $onehot0(a_grant) && (a_valid == (a_grant != 8'h00)) && !(a_valid && a_to)
             && (!a_valid || (a_grant == (8'h01 << a_idx)));
        chk("invariant_a", {31'd0, ok}, 32'd1);
        ok = $onehot0(b_grant) && (b_valid == (b_grant != 8'h00)) && !(b_valid && b_to)
             && (!b_valid || (b_grant == (8'h01 << b_idx)));
        chk("invariant_b", {31'd0, ok}, 32'd1);
    end

    initial begin
        // Rotation with done pulses: grant_idx 1..7 then 0, one idle cycle each.
        push(8'hFF, 1, 8'h00, 3'd0, 0, 0);
        push(8'hFF, 0, 8'h02, 3'd1, 1, 0);
        push(8'hFF, 1, 8'h00, 3'd1, 0, 0);
        push(8'hFF, 0, 8'h04, 3'd2, 1, 0);
        push(8'hFF, 1, 8'h00, 3'd2, 0, 0);
        push(8'hFF, 0, 8'h08, 3'd3, 1, 0);
        push(8'hFF, 1, 8'h00, 3'd3, 0, 0);
        push(8'hFF, 0, 8'h10, 3'd4, 1, 0);
        push(8'hFF, 1, 8'h00, 3'd4, 0, 0);
        push(8'hFF, 0, 8'h20, 3'd5, 1, 0);
        push(8'hFF, 1, 8'h00, 3'd5, 0, 0);
        push(8'hFF, 0, 8'h40, 3'd6, 1, 0);
        push(8'hFF, 1, 8'h00, 3'd6, 0, 0);
        push(8'hFF, 0, 8'h80, 3'd7, 1, 0);
        push(8'hFF, 1, 8'h00, 3'd7, 0, 0);
        push(8'hFF, 0, 8'h01, 3'd0, 1, 0);
        // Single requester 5, request drop, then wrap from ptr 6 to 0.
        push(8'hFF, 1, 8'h00, 3'd0, 0, 0);
        push(8'h20, 0, 8'h20, 3'd5, 1, 0);
        push(8'h20, 0, 8'h20, 3'd5, 1, 0);
        push(8'h00, 0, 8'h00, 3'd5, 0, 0);
        push(8'h21, 0, 8'h01, 3'd0, 1, 0);
        // The owner keeps the grant while the other bits toggle; next grant after owner+1.
        push(8'hFF, 0, 8'h01, 3'd0, 1, 0);
        push(8'h01, 0, 8'h01, 3'd0, 1, 0);
        push(8'h81, 0, 8'h01, 3'd0, 1, 0);
        push(8'h49, 1, 8'h00, 3'd0, 0, 0);
        push(8'h48, 0, 8'h08, 3'd3, 1, 0);
        // Move the grant to requester 4 before the reset test.
        push(8'h10, 1, 8'h00, 3'd3, 0, 0);
        push(8'h10, 0, 8'h10, 3'd4, 1, 0);

        rst_n = 1'b0; req = 8'h00; done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_grant", {24'd0, a_grant}, 32'h0);
        chk("rst_a_idx", {29'd0, a_idx}, 32'h0);
        chk("rst_a_valid", {31'd0, a_valid}, 32'h0);
        chk("rst_b_to", {31'd0, b_to}, 32'h0);
        rst_n = 1'b1;

        // First grant after reset goes to 0 and is held indefinitely without a limit.
        req = 8'hFF;
        tick();
        chk("t1_grant", {24'd0, a_grant}, 32'h01);
        chk("t1_idx", {29'd0, a_idx}, 32'h0);
        chk("t1_valid", {31'd0, a_valid}, 32'h1);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk($sformatf("t1_hold%0d_grant", i), {24'd0, a_grant}, 32'h01);
            chk($sformatf("t1_hold%0d_to", i), {31'd0, a_to}, 32'h0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            req = vecs[i].req;
            done = vecs[i].done;
            tick();
            chk($sformatf("v%0d_grant", i), {24'd0, a_grant}, {24'd0, vecs[i].grant});
            chk($sformatf("v%0d_idx", i), {29'd0, a_idx}, {29'd0, vecs[i].idx});
            chk($sformatf("v%0d_valid", i), {31'd0, a_valid}, {31'd0, vecs[i].valid});
            chk($sformatf("v%0d_to", i), {31'd0, a_to}, {31'd0, vecs[i].to});
        end

        // Asynchronous reset between edges while grant=8'h10 is active.
        done = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_grant", {24'd0, a_grant}, 32'h0);
        chk("arst_idx", {29'd0, a_idx}, 32'h0);
        chk("arst_valid", {31'd0, a_valid}, 32'h0);
        chk("arst_to", {31'd0, a_to}, 32'h0);
        req = 8'hFF;
        #2 rst_n = 1'b1;
        tick();
        chk("arst_regrant", {24'd0, a_grant}, 32'h01);
        chk("arst_regrant_idx", {29'd0, a_idx}, 32'h0);

        // Hold-limit release on instance b.
        rst_n = 1'b0; req = 8'h08; done = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("to_hold%0d_grant", i), {24'd0, b_grant}, 32'h08);
            chk($sformatf("to_hold%0d_to", i), {31'd0, b_to}, 32'h0);
        end
        tick();
        chk("to_rel_grant", {24'd0, b_grant}, 32'h0);
        chk("to_rel_pulse", {31'd0, b_to}, 32'h1);
        tick();
        chk("to_regrant", {24'd0, b_grant}, 32'h08);
        chk("to_regrant_idx", {29'd0, b_idx}, 32'h3);
        chk("to_pulse_end", {31'd0, b_to}, 32'h0);
        // done coinciding with the limit cycle is a normal release.
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("to2_hold%0d_grant", i), {24'd0, b_grant}, 32'h08);
        end
        done = 1'b1;
        tick();
        chk("to2_rel_grant", {24'd0, b_grant}, 32'h0);
        chk("to2_rel_to", {31'd0, b_to}, 32'h0);
        done = 1'b0;
        tick();
        chk("to2_regrant", {24'd0, b_grant}, 32'h08);
        chk("to2_after_to", {31'd0, b_to}, 32'h0);

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
